// File: rtl/mips_cpu_pkg.sv
// Shared CPU types for the multiply/divide unit: register word, HI/LO
// operation encoding and small helpers used on the operand path.
package mips_cpu_pkg;

    typedef logic [31:0] reg_t;

    localparam reg_t ZERO     = 32'h0000_0000;
    localparam reg_t ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    // Magnitude of a word; 0x80000000 maps onto itself, which is the correct
    // unsigned magnitude of the most negative value.
    function automatic reg_t abs_mag(input reg_t v, input logic is_signed);
        reg_t res;
        if (is_signed && v[31]) begin
            res = ZERO - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Two's-complement negate when requested.
    function automatic reg_t cond_neg(input reg_t v, input logic neg);
        reg_t res;
        if (neg) begin
            res = ZERO - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes. The first iteration is
// applied on the load edge so that 32 iterations complete 32 cycles after
// start; o_valid then pulses for one cycle while the results are held.
module div_core
    import mips_cpu_pkg::*;
(
    input  logic cpu_clk_50M,
    input  logic cpu_rst_n,
    input  logic i_start,
    input  logic i_cancel,
    input  reg_t i_dividend,
    input  reg_t i_divisor,
    output logic o_valid,
    output reg_t o_quotient,
    output reg_t o_remainder
);

    reg_t        r_rem;
    reg_t        r_quo;
    reg_t        r_dvs;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_valid;
    logic [63:0] w_first;
    logic [63:0] w_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Returns {remainder, quotient/shift register}.
    function automatic logic [63:0] div_step(input reg_t rem, input reg_t quo,
                                             input reg_t dvs);
        logic [32:0] shifted;
        logic [32:0] diff;
        logic [63:0] res;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        if (diff[32]) begin
            res = {shifted[31:0], quo[30:0], 1'b0};
        end else begin
            res = {diff[31:0], quo[30:0], 1'b1};
        end
        return res;
    endfunction

    // First step taken from the incoming operands, later steps from state.
    always_comb begin
        w_first = div_step(ZERO, i_dividend, i_divisor);
        w_next  = div_step(r_rem, r_quo, r_dvs);
    end

    // Iteration state: load on start, step while busy, pulse valid at the end.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_rem   <= ZERO;
            r_quo   <= ZERO;
            r_dvs   <= ZERO;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_cancel) begin
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_rem   <= w_first[63:32];
            r_quo   <= w_first[31:0];
            r_dvs   <= i_divisor;
            r_cnt   <= 5'd1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else if (r_busy) begin
            r_rem <= w_next[63:32];
            r_quo <= w_next[31:0];
            if (r_cnt == 5'd31) begin
                r_cnt   <= 5'd0;
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 5'd1;
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit. Multiplies run through a MUL_LAT-stage product
// pipeline; divides use the iterative div_core followed by one sign-fix
// cycle. Results appear on hi_o/lo_o for a single DONE cycle qualified by
// hilowe_o, and are held afterwards.
module muldiv_unit
    import mips_cpu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst_n,
    input  logic       start,
    input  muldiv_op_t op,
    input  reg_t       src_a,
    input  reg_t       src_b,
    input  logic       cancel,
    output logic       busy,
    output logic       done,
    output logic       hilowe_o,
    output reg_t       hi_o,
    output reg_t       lo_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

    state_t      r_state;
    muldiv_op_t  r_op;
    reg_t        r_a;
    reg_t        r_b;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [2:0]  r_cnt;
    reg_t        r_hi;
    reg_t        r_lo;

    logic        w_accept;
    logic        w_op_signed;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_div_start;
    reg_t        w_mag_a;
    reg_t        w_mag_b;
    logic        w_mul_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_product;
    logic [63:0] w_mul_res;
    logic        w_div_valid;
    reg_t        w_div_quo;
    reg_t        w_div_rem;
    reg_t        w_quo_fix;
    reg_t        w_rem_fix;

    // Request decode on the live inputs; only meaningful while accepting.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && start && !cancel;
        w_op_signed = (op == MULT) || (op == DIV);
        w_is_div    = (op == DIV) || (op == DIVU);
        w_div_zero  = (src_b == ZERO);
        w_div_start = w_accept && w_is_div && !w_div_zero;
        w_mag_a     = abs_mag(src_a, w_op_signed);
        w_mag_b     = abs_mag(src_b, w_op_signed);
    end

    // Full 64-bit product of the latched operands; sign-extending both to
    // 64 bits makes the truncated product correct for MULT and MULTU alike.
    always_comb begin
        w_mul_signed = (r_op == MULT);
        w_ext_a      = {{32{w_mul_signed & r_a[31]}}, r_a};
        w_ext_b      = {{32{w_mul_signed & r_b[31]}}, r_b};
        w_product    = w_ext_a * w_ext_b;
    end

    // The HI/LO registers form the last multiply stage, so MUL_LAT-1 product
    // registers sit in front of them.
    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign w_mul_res = w_product;
        end else begin : g_mul_pipe
            logic [63:0] r_prod [MUL_LAT-1];

            // Product shift pipeline, advancing every cycle.
            always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
                if (!cpu_rst_n) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        r_prod[i] <= 64'd0;
                    end
                end else begin
                    r_prod[0] <= w_product;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        r_prod[i] <= r_prod[i-1];
                    end
                end
            end

            assign w_mul_res = r_prod[MUL_LAT-2];
        end
    endgenerate

    div_core u_div_core (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .i_start     (w_div_start),
        .i_cancel    (cancel),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_valid     (w_div_valid),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // Sign correction for signed divides; flags are already clear for DIVU.
    always_comb begin
        w_quo_fix = cond_neg(w_div_quo, r_neg_q);
        w_rem_fix = cond_neg(w_div_rem, r_neg_r);
    end

    // Control FSM with operand latches and HI/LO result registers.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= S_IDLE;
            r_op    <= MULT;
            r_a     <= ZERO;
            r_b     <= ZERO;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= 3'd0;
            r_hi    <= ZERO;
            r_lo    <= ZERO;
        end else if (cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= src_a;
                        r_b     <= src_b;
                        r_op    <= op;
                        r_cnt   <= 3'd0;
                        r_neg_q <= w_op_signed & (src_a[31] ^ src_b[31]);
                        r_neg_r <= w_op_signed & src_a[31];
                        if (!w_is_div) begin
                            r_state <= S_MUL;
                        end else if (w_div_zero) begin
                            r_hi    <= src_a;
                            r_lo    <= ALL_ONES;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == MUL_LAST) begin
                        r_hi    <= w_mul_res[63:32];
                        r_lo    <= w_mul_res[31:0];
                        r_cnt   <= 3'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DIV: begin
                    if (w_div_valid) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_rem_fix;
                    r_lo    <= w_quo_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE) && !cancel;
    assign hilowe_o = (r_state == S_DONE) && !cancel;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized scoreboard bench for muldiv_unit.
module tb_muldiv_unit;
    import mips_cpu_pkg::*;

    logic       cpu_clk_50M = 1'b0;
    logic       cpu_rst_n   = 1'b0;
    logic       start       = 1'b0;
    muldiv_op_t op          = MULT;
    reg_t       src_a       = 32'h0;
    reg_t       src_b       = 32'h0;
    logic       cancel      = 1'b0;
    logic       busy;
    logic       done;
    logic       hilowe_o;
    reg_t       hi_o;
    reg_t       lo_o;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_res = 64'h0;

    muldiv_unit #(.MUL_LAT(2)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .hilowe_o    (hilowe_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: 64-bit arithmetic gives truncating division with the
    // dividend-signed remainder and no overflow for 0x80000000 / -1.
    function automatic logic [63:0] model(input muldiv_op_t o, input reg_t a, input reg_t b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        r  = 64'h0;
        case (o)
            MULT:  r = 64'(sa * sb);
            MULTU: r = {32'h0, a} * {32'h0, b};
            DIV: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {32'(rm), 32'(q)};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    // Drive a request in the current cycle (cycle 0) and queue its result.
    task automatic start_op(input muldiv_op_t o, input reg_t a, input reg_t b,
                            input logic [63:0] exp);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        exp_q.push_back(exp);
    endtask

    // Wait for done with a bounded budget, then check latency and result.
    task automatic wait_done(input string tag, input int exp_cyc, input bit hold);
        int n;
        logic [63:0] exp;
        n = 0;
        do begin
            tick();
            n++;
            if (hold) begin
                src_a = $urandom;
                src_b = $urandom;
                op    = muldiv_op_t'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
        end while (!done && n < 60);
        chk({tag, " latency"}, 64'(n), 64'(exp_cyc));
        chk({tag, " hilowe"}, 64'(hilowe_o), 64'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, " hi"}, 64'(hi_o), 64'(exp[63:32]));
            chk({tag, " lo"}, 64'(lo_o), 64'(exp[31:0]));
            last_res = exp;
        end else begin
            chk({tag, " queue"}, 64'(exp_q.size()), 64'd1);
        end
    endtask

    initial begin
        int pulses;
        muldiv_op_t o;
        reg_t a, b;
        int lat;

        // Reset state
        #3;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hilowe", 64'(hilowe_o), 64'd0);
        chk("rst hilo", {hi_o, lo_o}, 64'd0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        tick();

        // Directed multiplies and divides
        start_op(MULT, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_done("mult", 3, 1'b0);
        tick();
        start_op(MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA);
        wait_done("multu", 3, 1'b0);
        tick();
        start_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div -7/2", 34, 1'b0);
        tick();
        start_op(DIVU, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003);
        wait_done("divu 7/2", 34, 1'b0);
        tick();
        start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done("div ovf", 34, 1'b0);
        tick();
        start_op(DIVU, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF);
        wait_done("divu /0", 1, 1'b0);
        tick();
        start_op(DIV, 32'hFFFF_FFF7, 32'h0000_0000, 64'hFFFF_FFF7_FFFF_FFFF);
        wait_done("div /0", 1, 1'b0);
        tick();

        // Randomized operations against the model
        for (int i = 0; i < 8; i++) begin
            o = muldiv_op_t'(i % 4);
            a = $urandom;
            b = (i == 2) ? 32'h0 : ($urandom >> (i * 3));
            if (o == MULT || o == MULTU) lat = 3;
            else if (b == 32'h0) lat = 1;
            else lat = 34;
            start_op(o, a, b, model(o, a, b));
            wait_done("random", lat, 1'b0);
            tick();
        end

        // Cancel in cycle 10 of a divide
        start_op(DIV, 32'h1234_5678, 32'h0000_0011, 64'h0);
        void'(exp_q.pop_back());
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
        end
        chk("cancel busy before", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy after", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilowe_o) pulses++;
            tick();
        end
        chk("cancel no hilowe", 64'(pulses), 64'd0);
        chk("cancel hold hilo", {hi_o, lo_o}, last_res);

        // Cancel and start together in IDLE
        op = MULT; src_a = 32'h5; src_b = 32'h6; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel+start busy", 64'(busy), 64'd0);

        // Cancel in the DONE cycle
        start_op(MULT, 32'h0000_0009, 32'h0000_0009, 64'h0);
        void'(exp_q.pop_back());
        tick(); start = 1'b0;
        tick(); tick();
        chk("done-cancel busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        #1;
        chk("done-cancel hilowe", 64'(hilowe_o), 64'd0);
        chk("done-cancel done", 64'(done), 64'd0);
        tick();
        cancel = 1'b0;
        chk("done-cancel idle", 64'(busy), 64'd0);
        tick();

        // Start held with changing operands, then back-to-back start
        start_op(DIVU, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);
        wait_done("held start", 34, 1'b1);
        tick();
        start_op(MULTU, 32'h0000_0005, 32'h0000_0006, 64'h0000_0000_0000_001E);
        wait_done("back2back", 3, 1'b0);
        tick();

        // Reset in the middle of a multiply
        start_op(MULT, 32'h0000_1000, 32'h0000_2000, 64'h0);
        void'(exp_q.pop_back());
        tick();
        start = 1'b0;
        cpu_rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hilowe", 64'(hilowe_o), 64'd0);
        chk("midrst hilo", {hi_o, lo_o}, 64'd0);
        @(posedge cpu_clk_50M);
        #5;
        cpu_rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hilowe_o || busy) pulses++;
        end
        chk("postrst quiet", 64'(pulses), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter MUL_LAT, default 2: multiply pipeline depth in cycles, legal range 1..4.
REQ-002 cpu_clk_50M  in  1  sole clock, all state on rising edge.
REQ-003 cpu_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle request to begin an operation.
REQ-005 op  in  muldiv_op_t  MULT, MULTU, DIV or DIVU, sampled with start.
REQ-006 src_a  in  reg_t  rs operand; multiplicand or dividend.
REQ-007 src_b  in  reg_t  rt operand; multiplier or divisor.
REQ-008 cancel  in  1  pipeline flush; aborts any operation in flight.
REQ-009 busy  out  1  high while an operation is in flight; drives the pipeline stall.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 hilowe_o  out  1  HI/LO write enable, asserted together with done.
REQ-012 hi_o  out  reg_t  HI result: upper product or remainder.
REQ-013 lo_o  out  reg_t  LO result: lower product or quotient.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE; busy = (state != IDLE).
REQ-015 In IDLE with start=1 and cancel=0, src_a, src_b and op SHALL be latched; later changes on the inputs SHALL have no effect.
REQ-016 start while busy SHALL be ignored.
REQ-017 MULT/MULTU: IDLE->MUL, held MUL_LAT cycles ->DONE; start in cycle 0 gives done in cycle MUL_LAT+1.
REQ-018 The product SHALL be 64 bits: {hi_o,lo_o} = src_a*src_b, signed for MULT, unsigned for MULTU.
REQ-019 DIV/DIVU with divisor!=0: IDLE->DIV, 32 radix-2 restoring iterations on magnitudes, ->FIX for one cycle of sign correction, ->DONE; done in cycle 34.
REQ-020 Signed division SHALL truncate toward zero; the remainder SHALL take the dividend's sign; DIVU SHALL treat both operands as unsigned and skip sign correction in FIX.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo_o=0x80000000, hi_o=0.
REQ-022 Divisor==0: IDLE->DONE directly, done in cycle 1, hi_o=latched src_a, lo_o=0xFFFFFFFF, for both DIV and DIVU.
REQ-023 DONE SHALL last exactly one cycle with done=hilowe_o=1, then ->IDLE; hi_o/lo_o SHALL be stable and valid in that cycle.
REQ-024 A new start SHALL be accepted in the cycle after DONE (back-to-back).
REQ-025 cancel=1 SHALL force ->IDLE at the next edge from any state.
REQ-026 cancel in the DONE cycle SHALL suppress done and hilowe_o combinationally.
REQ-027 cancel and start together in IDLE: cancel SHALL win and no operation starts.
REQ-028 hi_o/lo_o SHALL hold their last value outside DONE; consumers SHALL qualify them with hilowe_o.

Reset
REQ-029 cpu_rst_n=0 SHALL set state=IDLE, the iteration counter to 0 and all operand/partial registers to 0.
REQ-030 During reset, busy=done=hilowe_o=0 and hi_o=lo_o=ZERO.
REQ-031 Reset mid-operation SHALL discard the operation without asserting hilowe_o.

Structure
REQ-032 muldiv_op_t (enum: MULT, MULTU, DIV, DIVU), reg_t and ZERO SHALL live in mips_cpu_pkg.
REQ-033 The FSM state type and MUL_LAT SHALL be local to muldiv_unit.
REQ-034 The divider datapath SHALL be one sub-module, div_core: magnitude operands in, 32-cycle iterative quotient/remainder out, with start/valid.
REQ-035 The multiplier SHALL be inferred in muldiv_unit with MUL_LAT register stages.

Verification
REQ-036 MULT 0xFFFFFFFE x 0x00000003 -> done in cycle 3, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; MULTU on the same operands -> hi_o=0x00000002, lo_o=0xFFFFFFFA.
REQ-037 DIV -7 / 2 -> done in cycle 34, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 7/2 -> lo_o=3, hi_o=1.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0; DIVU 5/0 -> done in cycle 1, hi_o=5, lo_o=0xFFFFFFFF.
REQ-039 cancel in cycle 10 of a DIV -> busy low from cycle 11, no hilowe_o pulse; cancel in the DONE cycle -> hilowe_o=0.
REQ-040 start held during a DIV with changing src -> ignored, result matches the first operands; start the cycle after DONE -> accepted.
REQ-041 cpu_rst_n low mid-MUL -> all outputs 0 immediately; after release, busy=0 and no done pulse.
